rs232in_rx: RTL and testbench

- Serial-to-parallel UART receiver feeding the memory-mapped serial peripheral.
- Deserialises an 8N1 stream (8E1 with the optional feature) from the RX pin.
- Presents each byte on `rs232in_data` with a one-cycle `rs232in_attention` strobe; the peripheral counts these strobes and reads the byte register.
- No FIFO: one holding register, overwritten by each new good frame.

---
 rtl/rs232in_rx.sv | 140 ++++++++++++++
 tb/tb_rs232in_rx.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs232in_rx.sv
// rs232in_rx: 8N1 UART receiver with a single holding register.
// RS232IN_PARITY_EN adds an even-parity bit (8E1 framing).
module rs232in_rx #(
  parameter int DIV  = 434,
  parameter int HALF = DIV / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  output logic       rs232in_attention,
  output logic [7:0] rs232in_data,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int CW = $clog2(DIV);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef RS232IN_PARITY_EN
    S_PAR,
`endif
    S_STOP,
    S_BRK
  } state_t;

  state_t          state;
  state_t          state_n;
  logic            rx_meta;
  logic            rx_s;
  logic [CW-1:0]   cnt;
  logic [2:0]      bitc;
  logic [7:0]      sh;
  logic            par_bad;
  logic            tick;
  logic            reload;
  logic            stop_tick;
  logic            att_d;
  logic            ferr_d;
  logic            perr_d;

  assign tick      = (cnt == '0);
  assign stop_tick = (state == S_STOP) && tick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (!rx_s) state_n = S_START;
      S_START: if (tick)  state_n = rx_s ? S_IDLE : S_DATA;
`ifdef RS232IN_PARITY_EN
      S_DATA:  if (tick && bitc == 3'd7) state_n = S_PAR;
      S_PAR:   if (tick)  state_n = S_STOP;
`else
      S_DATA:  if (tick && bitc == 3'd7) state_n = S_STOP;
`endif
      S_STOP:  if (tick)  state_n = rx_s ? S_IDLE : S_BRK;
      S_BRK:   if (rx_s)  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // A bad stop bit wins over a parity mismatch.
  always_comb begin
    att_d  = 1'b0;
    ferr_d = 1'b0;
    perr_d = 1'b0;
    unique case (1'b1)
      stop_tick && !rx_s:            ferr_d = 1'b1;
      stop_tick && rx_s && par_bad:  perr_d = 1'b1;
      stop_tick && rx_s && !par_bad: att_d  = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    reload = 1'b0;
    if (tick) begin
      unique case (state)
        S_START: reload = !rx_s;
        S_DATA:  reload = 1'b1;
`ifdef RS232IN_PARITY_EN
        S_PAR:   reload = 1'b1;
`endif
        default: reload = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta           <= 1'b1;
      rx_s              <= 1'b1;
      cnt               <= '0;
      bitc              <= 3'd0;
      sh                <= 8'h00;
      rs232in_attention <= 1'b0;
      rs232in_data      <= 8'h00;
      frame_err         <= 1'b0;
      parity_err        <= 1'b0;
    end else begin
      rx_meta           <= serial_in;
      rx_s              <= rx_meta;
      rs232in_attention <= att_d;
      frame_err         <= ferr_d;
      parity_err        <= perr_d;
      if (att_d) rs232in_data <= sh;
      if (state == S_IDLE && !rx_s)
        cnt <= CW'(HALF - 1);
      else if (reload)
        cnt <= CW'(DIV - 1);
      else if (!tick)
        cnt <= cnt - CW'(1);
      if (state == S_START && tick)
        bitc <= 3'd0;
      if (state == S_DATA && tick) begin
        bitc <= bitc + 3'd1;
        sh   <= {rx_s, sh[7:1]};
      end
    end
  end

`ifdef RS232IN_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      par_bad <= 1'b0;
    else if (state == S_PAR && tick)
      par_bad <= rx_s ^ (^sh);
  end
`else
  assign par_bad = 1'b0;
`endif

endmodule

// File: tb/tb_rs232in_rx.sv
// Bench for rs232in_rx at DIV=16; expected bytes go through a queue.
// Define RS232IN_PARITY_EN to exercise the 8E1 build.
module tb_rs232in_rx;

  localparam int DIV  = 16;
  localparam int HALF = DIV / 2;
`ifdef RS232IN_PARITY_EN
  localparam int LAT   = 2 + HALF + 9 * DIV + 1 + DIV;
  localparam int FRAME = 11 * DIV;
`else
  localparam int LAT   = 2 + HALF + 9 * DIV + 1;
  localparam int FRAME = 10 * DIV;
`endif

  logic       clk;
  logic       rst;
  logic       serial_in;
  logic       rs232in_attention;
  logic [7:0] rs232in_data;
  logic       frame_err;
  logic       parity_err;

  int checks;
  int failures;
  int cyc;
  int att_cnt;
  int ferr_cnt;
  int perr_cnt;
  int att_cyc;
  int prev_att_cyc;
  logic [7:0] exp_q[$];

  rs232in_rx #(.DIV(DIV), .HALF(HALF)) dut (
    .clk               (clk),
    .rst               (rst),
    .serial_in         (serial_in),
    .rs232in_attention (rs232in_attention),
    .rs232in_data      (rs232in_data),
    .frame_err         (frame_err),
    .parity_err        (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    logic [7:0] e;
    #1;
    if (rs232in_attention | frame_err | parity_err) begin
      checks++;
      if (int'(rs232in_attention) + int'(frame_err)
          + int'(parity_err) > 1) begin
        failures++;
        $display("FAIL strobe_overlap att=%0b ferr=%0b perr=%0b want one",
                 rs232in_attention, frame_err, parity_err);
      end
    end
    if (rs232in_attention) begin
      att_cnt++;
      prev_att_cyc = att_cyc;
      att_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_attention data=%h want none",
                 rs232in_data);
      end else begin
        e = exp_q.pop_front();
        if (rs232in_data !== e) begin
          failures++;
          $display("FAIL sb_data got=%h want=%h", rs232in_data, e);
        end
      end
    end
    if (frame_err) ferr_cnt++;
    if (parity_err) perr_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    serial_in = b;
    repeat (DIV) tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef RS232IN_PARITY_EN
    send_bit(^d);
`endif
    send_bit(stop);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    serial_in = 1'b1;
    repeat (5) tick();
    checks++;
    if (rs232in_attention !== 1'b0) begin
      failures++;
      $display("FAIL rst_att got=%b want=0", rs232in_attention);
    end
    checks++;
    if (rs232in_data !== 8'h00) begin
      failures++;
      $display("FAIL rst_data got=%h want=00", rs232in_data);
    end
    checks++;
    if (frame_err !== 1'b0 || parity_err !== 1'b0) begin
      failures++;
      $display("FAIL rst_err got=%b%b want=00", frame_err, parity_err);
    end
    rst = 1'b1;
    repeat (500) tick();
    checks++;
    if (att_cnt + ferr_cnt + perr_cnt !== 0) begin
      failures++;
      $display("FAIL idle_strobes got=%0d want=0",
               att_cnt + ferr_cnt + perr_cnt);
    end
    checks++;
    if (rs232in_data !== 8'h00) begin
      failures++;
      $display("FAIL idle_data got=%h want=00", rs232in_data);
    end
  endtask

  task automatic test_single();
    int a0;
    int c0;
    a0 = att_cnt;
    c0 = cyc;
    exp_q.push_back(8'h41);
    send_frame(8'h41, 1'b1);
    repeat (50) tick();
    checks++;
    if (att_cnt !== a0 + 1) begin
      failures++;
      $display("FAIL single_count got=%0d want=%0d", att_cnt, a0 + 1);
    end
    checks++;
    if (att_cyc - c0 !== LAT) begin
      failures++;
      $display("FAIL single_latency got=%0d want=%0d", att_cyc - c0, LAT);
    end
    checks++;
    if (rs232in_data !== 8'h41) begin
      failures++;
      $display("FAIL single_hold got=%h want=41", rs232in_data);
    end
  endtask

  task automatic test_back_to_back();
    int a0;
    a0 = att_cnt;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (DIV) tick();
    checks++;
    if (att_cnt !== a0 + 2) begin
      failures++;
      $display("FAIL b2b_count got=%0d want=%0d", att_cnt, a0 + 2);
    end
    checks++;
    if (att_cyc - prev_att_cyc !== FRAME) begin
      failures++;
      $display("FAIL b2b_spacing got=%0d want=%0d",
               att_cyc - prev_att_cyc, FRAME);
    end
  endtask

  task automatic test_glitch();
    int a0;
    int f0;
    a0 = att_cnt;
    f0 = ferr_cnt;
    serial_in = 1'b0;
    repeat (4) tick();
    serial_in = 1'b1;
    repeat (3 * DIV) tick();
    checks++;
    if (att_cnt !== a0 || ferr_cnt !== f0) begin
      failures++;
      $display("FAIL glitch_strobe got=%0d/%0d want=%0d/%0d",
               att_cnt, ferr_cnt, a0, f0);
    end
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    repeat (DIV) tick();
    checks++;
    if (att_cnt !== a0 + 1 || rs232in_data !== 8'h5A) begin
      failures++;
      $display("FAIL glitch_next got=%0d/%h want=%0d/5a",
               att_cnt, rs232in_data, a0 + 1);
    end
  endtask

  task automatic test_frame_err();
    int a0;
    int f0;
    a0 = att_cnt;
    f0 = ferr_cnt;
    send_frame(8'h33, 1'b0);
    repeat (100) tick();
    checks++;
    if (ferr_cnt !== f0 + 1) begin
      failures++;
      $display("FAIL ferr_count got=%0d want=%0d", ferr_cnt, f0 + 1);
    end
    checks++;
    if (att_cnt !== a0 || rs232in_data !== 8'h5A) begin
      failures++;
      $display("FAIL ferr_data got=%0d/%h want=%0d/5a",
               att_cnt, rs232in_data, a0);
    end
    serial_in = 1'b1;
    repeat (20) tick();
    exp_q.push_back(8'h77);
    send_frame(8'h77, 1'b1);
    repeat (DIV) tick();
    checks++;
    if (att_cnt !== a0 + 1 || ferr_cnt !== f0 + 1) begin
      failures++;
      $display("FAIL ferr_recover got=%0d/%0d want=%0d/%0d",
               att_cnt, ferr_cnt, a0 + 1, f0 + 1);
    end
  endtask

  task automatic test_reset_mid();
    int a0;
    int f0;
    int p0;
    logic [7:0] d;
    d = 8'hC3;
    a0 = att_cnt;
    f0 = ferr_cnt;
    p0 = perr_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    serial_in = d[4];
    repeat (DIV / 2) tick();
    rst = 1'b0;
    #1;
    checks++;
    if (rs232in_data !== 8'h00) begin
      failures++;
      $display("FAIL midrst_data got=%h want=00", rs232in_data);
    end
    checks++;
    if ({rs232in_attention, frame_err, parity_err} !== 3'b000) begin
      failures++;
      $display("FAIL midrst_strobes got=%b want=000",
               {rs232in_attention, frame_err, parity_err});
    end
    serial_in = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    repeat (200) tick();
    checks++;
    if (att_cnt !== a0 || ferr_cnt !== f0 || perr_cnt !== p0) begin
      failures++;
      $display("FAIL midrst_after got=%0d/%0d/%0d want=%0d/%0d/%0d",
               att_cnt, ferr_cnt, perr_cnt, a0, f0, p0);
    end
  endtask

`ifdef RS232IN_PARITY_EN
  task automatic test_parity();
    int a0;
    int p0;
    logic [7:0] d;
    d = 8'hC3;
    a0 = att_cnt;
    p0 = perr_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(1'b1);
    send_bit(1'b1);
    repeat (DIV) tick();
    checks++;
    if (perr_cnt !== p0 + 1 || att_cnt !== a0) begin
      failures++;
      $display("FAIL par_bad got=%0d/%0d want=%0d/%0d",
               perr_cnt, att_cnt, p0 + 1, a0);
    end
    checks++;
    if (rs232in_data !== 8'h00) begin
      failures++;
      $display("FAIL par_bad_data got=%h want=00", rs232in_data);
    end
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1);
    repeat (DIV) tick();
    checks++;
    if (att_cnt !== a0 + 1 || rs232in_data !== 8'hC3) begin
      failures++;
      $display("FAIL par_good got=%0d/%h want=%0d/c3",
               att_cnt, rs232in_data, a0 + 1);
    end
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    att_cnt = 0;
    ferr_cnt = 0;
    perr_cnt = 0;
    att_cyc = 0;
    prev_att_cyc = 0;
    rst = 1'b0;
    serial_in = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
`ifdef RS232IN_PARITY_EN
    test_parity();
`endif
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL sb_leftover got=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
